mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LDQ_ENTRIES, default CORE_PKG::LDQ_ENTRIES (16), SHALL size ld index ports to $clog2(LDQ_ENTRIES) bits (LIW).
REQ-002 Parameter SDQ_ENTRIES, default CORE_PKG::SDQ_ENTRIES (16), SHALL size st index ports to $clog2(SDQ_ENTRIES) bits (SIW).
REQ-003 Parameter ST_PRESSURE, default 4: store-priority threshold on st_pending_cnt.
REQ-004 Parameter STARVE_LIMIT, default 8: wait-cycle limit forcing a grant.
REQ-005 Ports SHALL be:
 clk  in  1  single clock, rising edge
 rst  in  1  asynchronous, active-low reset
 flush  in  1  pipeline flush, kills in-flight load
 ld_req_vld / ld_req_rdy  in / out  1  load-queue issue handshake
 ld_req_idx  in  LIW  issuing LDQ entry
 ld_req_addr  in  32  load address
 st_req_vld / st_req_rdy  in / out  1  committed-store drain handshake
 st_req_idx  in  SIW  draining SDQ entry
 st_req_addr, st_req_data  in  32 each  store address, data
 st_req_mask  in  4  byte enables
 st_pending_cnt  in  $clog2(SDQ_ENTRIES)+1  committed stores awaiting drain
 mem_req_vld / mem_req_rdy  out / in  1  data-cache port handshake
 mem_req_we  out  1  1=store
 mem_req_addr, mem_req_wdata  out  32 each; mem_req_mask  out  4
 mem_resp_vld  in  1; mem_resp_rdata  in  32  cache response
 ld_resp_vld  out  1; ld_resp_idx  out  LIW; ld_resp_data  out  32  load writeback
 st_done_vld  out  1; st_done_idx  out  SIW  store-drain completion
 busy  out  1  state != IDLE

Function
REQ-006 FSM states IDLE, REQ, WAIT; one cache transaction outstanding at most.
REQ-007 IDLE: exactly one of ld_req_rdy/st_req_rdy high, per grant; both low in REQ/WAIT.
REQ-008 Grant: only one side valid -> that side; both valid -> store if st_pending_cnt >= ST_PRESSURE, else load; neither -> load rdy default.
REQ-009 On vld&&rdy in IDLE, payload, side, index SHALL register; next cycle state REQ, mem_req_vld=1 (1-cycle latency).
REQ-010 REQ: mem_req_* held stable until mem_req_rdy; then WAIT.
REQ-011 WAIT: mem_resp_vld -> one-cycle pulse of ld_resp_vld (idx, rdata) or st_done_vld (idx), state IDLE; new acceptance no earlier than that IDLE cycle (max one op per 3 cycles).
REQ-012 mem_resp_vld outside WAIT SHALL be ignored.
REQ-013 flush: ld_req_rdy forced 0 that cycle; in-flight load (REQ/WAIT) completes on port but ld_resp_vld suppressed; stores never affected.
REQ-014 Flush and load acceptance same cycle: flush wins, no acceptance.

Reset
REQ-015 rst low SHALL asynchronously force IDLE, all outputs 0, kill flag and starvation counters 0; mid-transaction ops abandoned, no resp/done emitted.

Configuration
REQ-016 Macro MEM_ARB_STARVE_EN defined: per-side counter increments each IDLE cycle the side is valid but not granted, saturates at STARVE_LIMIT; at limit that side wins over REQ-008; cleared on grant; both at limit -> store.
REQ-017 MEM_ARB_STARVE_EN undefined: counters absent, pure REQ-008 priority.

Verification
REQ-018 ld_req idx=15 addr=5108, mem_req_rdy=1, resp 2 cycles later rdata=0xDEAD -> mem_req_vld cycle after accept, we=0, ld_resp_vld idx=15 data=0xDEAD one cycle.
REQ-019 Both valid, st_pending_cnt=5 -> store granted, mem_req_we=1, mask/data forwarded; st_pending_cnt=2 -> load granted.
REQ-020 mem_req_rdy low 3 cycles -> payload stable, state REQ, both rdy low.
REQ-021 flush during WAIT of load idx=3 -> no ld_resp_vld, next op accepted after resp.
REQ-022 MEM_ARB_STARVE_EN, st_pending_cnt=8, load held valid -> load granted after 8 store grants.
REQ-023 rst low during WAIT, then resp arrives -> outputs 0, no pulses, IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-cache port between load issue and committed-store drain
// Optional starvation guard: define MEM_ARB_STARVE_EN.
module mem_port_arbiter #(
  parameter int LDQ_ENTRIES  = 16,
  parameter int SDQ_ENTRIES  = 16,
  parameter int ST_PRESSURE  = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int LIW = $clog2(LDQ_ENTRIES),
  localparam int SIW = $clog2(SDQ_ENTRIES),
  localparam int CW  = $clog2(SDQ_ENTRIES) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           ld_req_vld,
  output logic           ld_req_rdy,
  input  logic [LIW-1:0] ld_req_idx,
  input  logic [31:0]    ld_req_addr,
  input  logic           st_req_vld,
  output logic           st_req_rdy,
  input  logic [SIW-1:0] st_req_idx,
  input  logic [31:0]    st_req_addr,
  input  logic [31:0]    st_req_data,
  input  logic [3:0]     st_req_mask,
  input  logic [CW-1:0]  st_pending_cnt,
  output logic           mem_req_vld,
  input  logic           mem_req_rdy,
  output logic           mem_req_we,
  output logic [31:0]    mem_req_addr,
  output logic [31:0]    mem_req_wdata,
  output logic [3:0]     mem_req_mask,
  input  logic           mem_resp_vld,
  input  logic [31:0]    mem_resp_rdata,
  output logic           ld_resp_vld,
  output logic [LIW-1:0] ld_resp_idx,
  output logic [31:0]    ld_resp_data,
  output logic           st_done_vld,
  output logic [SIW-1:0] st_done_idx,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           side_q, side_d;
  logic [LIW-1:0] ld_idx_q, ld_idx_d;
  logic [SIW-1:0] st_idx_q, st_idx_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     mask_q, mask_d;
  logic           kill_q, kill_d;
  logic           ld_resp_vld_q, ld_resp_vld_d;
  logic [LIW-1:0] ld_resp_idx_q, ld_resp_idx_d;
  logic [31:0]    ld_resp_data_q, ld_resp_data_d;
  logic           st_done_vld_q, st_done_vld_d;
  logic [SIW-1:0] st_done_idx_q, st_done_idx_d;

  logic idle;
  logic ld_cand;
  logic st_press;
  logic grant_st;
  logic ld_acc;
  logic st_acc;

  assign idle     = (state_q == S_IDLE);
  // A flushed load is not a candidate, so a waiting store can still take the port.
  assign ld_cand  = ld_req_vld & ~flush;
  assign st_press = (32'(st_pending_cnt) >= ST_PRESSURE);

`ifdef MEM_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  logic [SCW-1:0] ld_starve_q, ld_starve_d;
  logic [SCW-1:0] st_starve_q, st_starve_d;

  always_comb begin
    ld_starve_d = ld_starve_q;
    st_starve_d = st_starve_q;
    if (idle) begin
      if (ld_acc)                                  ld_starve_d = '0;
      else if (ld_cand && ld_starve_q != STARVE_MAX) ld_starve_d = ld_starve_q + SCW'(1);
      if (st_acc)                                  st_starve_d = '0;
      else if (st_req_vld && st_starve_q != STARVE_MAX) st_starve_d = st_starve_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_starve_q <= '0;
      st_starve_q <= '0;
    end else begin
      ld_starve_q <= ld_starve_d;
      st_starve_q <= st_starve_d;
    end
  end
`endif

  always_comb begin
    grant_st = 1'b0;
    if (st_req_vld && !ld_cand) begin
      grant_st = 1'b1;
    end else if (st_req_vld && ld_cand) begin
`ifdef MEM_ARB_STARVE_EN
      if (st_starve_q == STARVE_MAX)      grant_st = 1'b1;
      else if (ld_starve_q == STARVE_MAX) grant_st = 1'b0;
      else                                grant_st = st_press;
`else
      grant_st = st_press;
`endif
    end
  end

  // Gated by rst so both ready lines read 0 while reset is held.
  assign ld_req_rdy = rst & idle & ~grant_st & ~flush;
  assign st_req_rdy = rst & idle & grant_st;
  assign ld_acc     = ld_req_vld & ld_req_rdy;
  assign st_acc     = st_req_vld & st_req_rdy;

  always_comb begin
    state_d        = state_q;
    side_d         = side_q;
    ld_idx_d       = ld_idx_q;
    st_idx_d       = st_idx_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mask_d         = mask_q;
    kill_d         = kill_q;
    ld_resp_vld_d  = 1'b0;
    ld_resp_idx_d  = ld_resp_idx_q;
    ld_resp_data_d = ld_resp_data_q;
    st_done_vld_d  = 1'b0;
    st_done_idx_d  = st_done_idx_q;
    unique case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (st_acc) begin
          state_d  = S_REQ;
          side_d   = 1'b1;
          st_idx_d = st_req_idx;
          addr_d   = st_req_addr;
          wdata_d  = st_req_data;
          mask_d   = st_req_mask;
        end else if (ld_acc) begin
          state_d  = S_REQ;
          side_d   = 1'b0;
          ld_idx_d = ld_req_idx;
          addr_d   = ld_req_addr;
          wdata_d  = '0;
          mask_d   = '0;
        end
      end
      S_REQ: begin
        if (flush && !side_q) kill_d = 1'b1;
        if (mem_req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush && !side_q) kill_d = 1'b1;
        if (mem_resp_vld) begin
          state_d = S_IDLE;
          if (side_q) begin
            st_done_vld_d = 1'b1;
            st_done_idx_d = st_idx_q;
          end else if (!kill_q && !flush) begin
            ld_resp_vld_d  = 1'b1;
            ld_resp_idx_d  = ld_idx_q;
            ld_resp_data_d = mem_resp_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      side_q         <= 1'b0;
      ld_idx_q       <= '0;
      st_idx_q       <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      mask_q         <= '0;
      kill_q         <= 1'b0;
      ld_resp_vld_q  <= 1'b0;
      ld_resp_idx_q  <= '0;
      ld_resp_data_q <= '0;
      st_done_vld_q  <= 1'b0;
      st_done_idx_q  <= '0;
    end else begin
      state_q        <= state_d;
      side_q         <= side_d;
      ld_idx_q       <= ld_idx_d;
      st_idx_q       <= st_idx_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      mask_q         <= mask_d;
      kill_q         <= kill_d;
      ld_resp_vld_q  <= ld_resp_vld_d;
      ld_resp_idx_q  <= ld_resp_idx_d;
      ld_resp_data_q <= ld_resp_data_d;
      st_done_vld_q  <= st_done_vld_d;
      st_done_idx_q  <= st_done_idx_d;
    end
  end

  assign mem_req_vld   = (state_q == S_REQ);
  assign mem_req_we    = side_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_mask  = mask_q;
  assign ld_resp_vld   = ld_resp_vld_q;
  assign ld_resp_idx   = ld_resp_idx_q;
  assign ld_resp_data  = ld_resp_data_q;
  assign st_done_vld   = st_done_vld_q;
  assign st_done_idx   = st_done_idx_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int ST_PRESSURE  = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ld_req_vld, ld_req_rdy;
  logic [3:0]  ld_req_idx;
  logic [31:0] ld_req_addr;
  logic        st_req_vld, st_req_rdy;
  logic [3:0]  st_req_idx;
  logic [31:0] st_req_addr, st_req_data;
  logic [3:0]  st_req_mask;
  logic [4:0]  st_pending_cnt;
  logic        mem_req_vld, mem_req_rdy, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_vld;
  logic [31:0] mem_resp_rdata;
  logic        ld_resp_vld;
  logic [3:0]  ld_resp_idx;
  logic [31:0] ld_resp_data;
  logic        st_done_vld;
  logic [3:0]  st_done_idx;
  logic        busy;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_vld(ld_req_vld), .ld_req_rdy(ld_req_rdy), .ld_req_idx(ld_req_idx), .ld_req_addr(ld_req_addr),
    .st_req_vld(st_req_vld), .st_req_rdy(st_req_rdy), .st_req_idx(st_req_idx), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_mask(st_req_mask), .st_pending_cnt(st_pending_cnt),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
    .mem_resp_vld(mem_resp_vld), .mem_resp_rdata(mem_resp_rdata),
    .ld_resp_vld(ld_resp_vld), .ld_resp_idx(ld_resp_idx), .ld_resp_data(ld_resp_data),
    .st_done_vld(st_done_vld), .st_done_idx(st_done_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: at most one transaction in flight, described by its fields and whether it reached the cache.
  bit          t_busy, t_sent, t_side, t_kill;
  logic [3:0]  t_lidx, t_sidx, t_mask;
  logic [31:0] t_addr, t_data;
  bit          p_ld, p_st;
  logic [3:0]  p_lidx, p_sidx;
  logic [31:0] p_data;
  int          lw, sw;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t_busy = 0; t_sent = 0; t_side = 0; t_kill = 0;
    t_lidx = '0; t_sidx = '0; t_mask = '0; t_addr = '0; t_data = '0;
    p_ld = 0; p_st = 0; p_lidx = '0; p_sidx = '0; p_data = '0;
    lw = 0; sw = 0;
  endtask

  function automatic bit pick_store(bit lv, bit sv, int cnt);
    if (!sv) return 1'b0;
    if (!lv) return 1'b1;
`ifdef MEM_ARB_STARVE_EN
    if (sw >= STARVE_LIMIT) return 1'b1;
    if (lw >= STARVE_LIMIT) return 1'b0;
`endif
    return cnt >= ST_PRESSURE;
  endfunction

  task automatic check_outputs();
    bit lv, gs;
    lv = ld_req_vld && !flush;
    gs = pick_store(lv, st_req_vld, int'(st_pending_cnt));
    chk("ld_req_rdy", ld_req_rdy, !t_busy && !gs && !flush);
    chk("st_req_rdy", st_req_rdy, !t_busy && gs);
    chk("busy", busy, t_busy);
    chk("mem_req_vld", mem_req_vld, t_busy && !t_sent);
    if (t_busy && !t_sent) begin
      chk("mem_req_we", mem_req_we, t_side);
      chk("mem_req_addr", mem_req_addr, t_addr);
      if (t_side) begin
        chk("mem_req_wdata", mem_req_wdata, t_data);
        chk("mem_req_mask", mem_req_mask, t_mask);
      end
    end
    chk("ld_resp_vld", ld_resp_vld, p_ld);
    if (p_ld) begin
      chk("ld_resp_idx", ld_resp_idx, p_lidx);
      chk("ld_resp_data", ld_resp_data, p_data);
    end
    chk("st_done_vld", st_done_vld, p_st);
    if (p_st) chk("st_done_idx", st_done_idx, p_sidx);
  endtask

  task automatic model_step();
    bit lv, gs, acc_l, acc_s;
    lv = ld_req_vld && !flush;
    gs = pick_store(lv, st_req_vld, int'(st_pending_cnt));
    p_ld = 0;
    p_st = 0;
    if (!t_busy) begin
      acc_s = st_req_vld && gs;
      acc_l = lv && !gs;
`ifdef MEM_ARB_STARVE_EN
      if (acc_l) lw = 0; else if (lv) lw = (lw + 1 > STARVE_LIMIT) ? STARVE_LIMIT : lw + 1;
      if (acc_s) sw = 0; else if (st_req_vld) sw = (sw + 1 > STARVE_LIMIT) ? STARVE_LIMIT : sw + 1;
`endif
      if (acc_s) begin
        t_busy = 1; t_sent = 0; t_side = 1; t_kill = 0;
        t_sidx = st_req_idx; t_addr = st_req_addr; t_data = st_req_data; t_mask = st_req_mask;
      end else if (acc_l) begin
        t_busy = 1; t_sent = 0; t_side = 0; t_kill = 0;
        t_lidx = ld_req_idx; t_addr = ld_req_addr;
      end
    end else begin
      if (flush && !t_side) t_kill = 1;
      if (!t_sent) begin
        if (mem_req_rdy) t_sent = 1;
      end else if (mem_resp_vld) begin
        t_busy = 0;
        if (t_side) begin
          p_st = 1; p_sidx = t_sidx;
        end else if (!t_kill) begin
          p_ld = 1; p_lidx = t_lidx; p_data = mem_resp_rdata;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    flush = 0; ld_req_vld = 0; st_req_vld = 0; mem_resp_vld = 0; mem_req_rdy = 0;
  endtask

  // From REQ state: hand the request to the cache, return a response, observe the pulse.
  task automatic finish_op();
    ld_req_vld = 0; st_req_vld = 0; mem_req_rdy = 1; mem_resp_vld = 0;
    tick();
    mem_resp_rdata = $urandom;
    mem_resp_vld = 1;
    tick();
    mem_resp_vld = 0;
    tick();
  endtask

  initial begin
    int nst;
    bit got;
    rst = 0; flush = 0; ld_req_vld = 0; st_req_vld = 0; mem_req_rdy = 0; mem_resp_vld = 0;
    ld_req_idx = '0; ld_req_addr = '0; st_req_idx = '0; st_req_addr = '0; st_req_data = '0;
    st_req_mask = '0; st_pending_cnt = '0; mem_resp_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_rdy", ld_req_rdy, 0);
    chk("rst_st_rdy", st_req_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_vld", mem_req_vld, 0);
    chk("rst_addr", mem_req_addr, 0);
    @(posedge clk); #1;
    rst = 1;
    tick();

    // Load idx 15, response two cycles after acceptance.
    ld_req_vld = 1; ld_req_idx = 4'd15; ld_req_addr = 32'd5108; mem_req_rdy = 1;
    tick();
    chk("r018_mem_vld", mem_req_vld, 1);
    chk("r018_we", mem_req_we, 0);
    chk("r018_addr", mem_req_addr, 32'd5108);
    ld_req_vld = 0;
    tick();
    mem_resp_vld = 1; mem_resp_rdata = 32'hDEAD;
    tick();
    chk("r018_resp_vld", ld_resp_vld, 1);
    chk("r018_resp_idx", ld_resp_idx, 15);
    chk("r018_resp_data", ld_resp_data, 32'hDEAD);
    mem_resp_vld = 0;
    tick();
    chk("r018_pulse_end", ld_resp_vld, 0);

    // Both valid: store pressure wins at 5, load wins at 2.
    ld_req_vld = 1; ld_req_idx = 4'd2; ld_req_addr = 32'h100;
    st_req_vld = 1; st_req_idx = 4'd6; st_req_addr = 32'h200; st_req_data = 32'hCAFE_F00D; st_req_mask = 4'b1010;
    st_pending_cnt = 5'd5;
    tick();
    chk("r019_we", mem_req_we, 1);
    chk("r019_wdata", mem_req_wdata, 32'hCAFE_F00D);
    chk("r019_mask", mem_req_mask, 4'b1010);
    finish_op();
    ld_req_vld = 1; st_req_vld = 1; st_pending_cnt = 5'd2;
    tick();
    chk("r019_ld_we", mem_req_we, 0);
    chk("r019_ld_addr", mem_req_addr, 32'h100);
    finish_op();

    // Cache stalls three cycles; payload must hold while new requests wait.
    ld_req_vld = 1; ld_req_idx = 4'd4; ld_req_addr = 32'hABC0; mem_req_rdy = 0;
    tick();
    ld_req_addr = 32'h1111; st_req_vld = 1; st_req_addr = 32'h2222;
    repeat (3) begin
      tick();
      chk("r020_addr", mem_req_addr, 32'hABC0);
      chk("r020_rdy", {ld_req_rdy, st_req_rdy}, 0);
    end
    finish_op();

    // Flush during WAIT of load idx 3 suppresses its writeback.
    quiet();
    ld_req_vld = 1; ld_req_idx = 4'd3; ld_req_addr = 32'h300; mem_req_rdy = 1;
    tick();
    ld_req_vld = 0;
    tick();
    flush = 1;
    tick();
    flush = 0; mem_resp_vld = 1; mem_resp_rdata = 32'h1234;
    tick();
    chk("r021_no_resp", ld_resp_vld, 0);
    mem_resp_vld = 0; ld_req_vld = 1; ld_req_idx = 4'd7; ld_req_addr = 32'h700;
    tick();
    chk("r021_next_acc", busy, 1);
    finish_op();

    // Flush beats a same-cycle load acceptance.
    ld_req_vld = 1; flush = 1;
    tick();
    chk("r014_no_acc", busy, 0);
    flush = 0; ld_req_vld = 0;
    tick();

    // Reset mid-WAIT, response arrives while held.
    ld_req_vld = 1; ld_req_idx = 4'd9; mem_req_rdy = 1;
    tick();
    ld_req_vld = 0;
    tick();
    #2 rst = 0;
    #1;
    chk("r023_busy", busy, 0);
    chk("r023_mem_vld", mem_req_vld, 0);
    chk("r023_ld_rdy", ld_req_rdy, 0);
    mem_resp_vld = 1;
    @(posedge clk); #1;
    mem_resp_vld = 0;
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    chk("r023_ld_resp", ld_resp_vld, 0);
    chk("r023_st_done", st_done_vld, 0);
    chk("r023_addr", mem_req_addr, 0);
    tick();

    // Persistent store pressure with a load held valid.
    ld_req_vld = 1; st_req_vld = 1; st_pending_cnt = 5'd8; mem_req_rdy = 1; mem_resp_vld = 1;
    nst = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      check_outputs();
      if (ld_req_rdy) got = 1;
      else if (st_req_rdy) nst++;
      @(posedge clk);
      model_step();
      #1;
    end
`ifdef MEM_ARB_STARVE_EN
    chk("r022_ld_granted", got, 1);
    chk("r022_st_grants", nst, STARVE_LIMIT);
`else
    chk("r022_no_ld_grant", got, 0);
`endif
    ld_req_vld = 0; st_req_vld = 0;
    repeat (4) tick();
    mem_resp_vld = 0;
    tick();

    for (int c = 0; c < 800; c++) begin
      flush          = ($urandom_range(0, 9) == 0);
      ld_req_vld     = $urandom_range(0, 1) == 1;
      ld_req_idx     = 4'($urandom);
      ld_req_addr    = $urandom;
      st_req_vld     = $urandom_range(0, 1) == 1;
      st_req_idx     = 4'($urandom);
      st_req_addr    = $urandom;
      st_req_data    = $urandom;
      st_req_mask    = 4'($urandom);
      st_pending_cnt = 5'($urandom_range(0, 16));
      mem_req_rdy    = $urandom_range(0, 4) < 3;
      mem_resp_vld   = $urandom_range(0, 1) == 1;
      mem_resp_rdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
